// File: rtl/av_menu_pkg.sv
// av_menu_pkg: shared types and constants for the pause/menu overlay controller
package av_menu_pkg;
  typedef enum logic [2:0] {IDLE, PLAY, FADE_IN, MENU, FADE_OUT, COUNTDOWN} state_t;
  typedef struct packed {
    logic select;
    logic down;
    logic up;
    logic pause;
  } pend_t;
  localparam logic [1:0] ITEM_RESUME = 2'd0;
  localparam logic [1:0] ITEM_RESTART = 2'd1;
  localparam logic [1:0] ITEM_QUIT = 2'd2;
  localparam int N_ITEMS_DEFAULT = 3;
  localparam int FADE_MAX_DEFAULT = 15;
  localparam int COUNTDOWN_FRAMES_DEFAULT = 180;
  // Move the highlight one entry up or down, wrapping between 0 and last.
  function automatic logic [1:0] menu_move(input logic [1:0] item, input logic up, input logic [1:0] last);
    return up ? ((item == 2'd0) ? last : item - 2'd1) : ((item == last) ? 2'd0 : item + 2'd1);
  endfunction
endpackage

// File: rtl/av_event_latch.sv
// av_event_latch: frame_start generation and sticky per-frame button flags
// Ports: i_clk/i_rst_n clock and async active-low reset; i_hcount/i_vcount raster
// position; i_btn_* one-cycle button pulses; o_frame_start one cycle after the
// raster origin; o_pend the flags gathered since the previous frame_start.
module av_event_latch
  import av_menu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [10:0] i_hcount,
  input  logic [9:0]  i_vcount,
  input  logic        i_btn_pause,
  input  logic        i_btn_up,
  input  logic        i_btn_down,
  input  logic        i_btn_select,
  output logic        o_frame_start,
  output pend_t       o_pend
);
  pend_t w_pulse;
  pend_t r_pend;
  logic  r_frame_start;
  assign w_pulse = {i_btn_select, i_btn_down, i_btn_up, i_btn_pause};
  // On the frame_start cycle the FSM consumes the old flags, so they reload with
  // only this cycle's pulses; a pulse arriving right then carries to the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_frame_start <= 1'b0;
      r_pend <= '0;
    end else begin
      r_frame_start <= (i_hcount == 11'd0) && (i_vcount == 10'd0);
      r_pend <= r_frame_start ? w_pulse : (r_pend | w_pulse);
    end
  assign o_frame_start = r_frame_start;
  assign o_pend = r_pend;
endmodule

// File: rtl/av_menu_controller.sv
// av_menu_controller: pause/menu overlay sequencer for the 1024x768 video path
// Ports: clk65/reset_n clock and async active-low reset; hcount/vcount raster;
// btn_* one-cycle button pulses; song_done level. Outputs: pause overlay enable,
// menu_item highlight, fade_level opacity, game_run, countdown digit (3/2/1, 0 when
// idle), restart_pulse/quit_pulse one-cycle strobes. State moves only at frame_start.
module av_menu_controller
  import av_menu_pkg::*;
#(
  parameter int N_ITEMS = N_ITEMS_DEFAULT,
  parameter int FADE_MAX = FADE_MAX_DEFAULT,
  parameter int COUNTDOWN_FRAMES = COUNTDOWN_FRAMES_DEFAULT
) (
  input  logic        clk65,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        btn_pause,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_select,
  input  logic        song_done,
  output logic        pause,
  output logic [1:0]  menu_item,
  output logic [3:0]  fade_level,
  output logic        game_run,
  output logic [1:0]  countdown,
  output logic        restart_pulse,
  output logic        quit_pulse
);
  localparam int CW = $clog2(COUNTDOWN_FRAMES + 1);
  localparam logic [3:0] FMAX = 4'(FADE_MAX);
  localparam logic [1:0] ILAST = 2'(N_ITEMS - 1);
  localparam logic [CW-1:0] C_LAST = CW'(COUNTDOWN_FRAMES - 1);
  localparam logic [CW-1:0] C_THIRD = CW'(COUNTDOWN_FRAMES / 3);
  localparam logic [CW-1:0] C_TWO = CW'(2 * COUNTDOWN_FRAMES / 3);
  logic          w_fs;
  pend_t         w_pend;
  state_t        r_state, w_state;
  logic [1:0]    r_item, w_item;
  logic [3:0]    r_fade, w_fade;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_restart, w_restart, r_quit, w_quit;
  logic          w_up_step, w_dn_step;
  av_event_latch u_events (
    .i_clk        (clk65),
    .i_rst_n      (reset_n),
    .i_hcount     (hcount),
    .i_vcount     (vcount),
    .i_btn_pause  (btn_pause),
    .i_btn_up     (btn_up),
    .i_btn_down   (btn_down),
    .i_btn_select (btn_select),
    .o_frame_start(w_fs),
    .o_pend       (w_pend)
  );
  // Every entry into FADE_IN/FADE_OUT also takes that frame's fade step, so a
  // fade-in shows levels 1..FADE_MAX on consecutive frames and lands in MENU on
  // the frame it reaches FADE_MAX; a fade-out lands in COUNTDOWN on reaching 0.
  always_comb begin
    w_state = r_state;
    w_item = r_item;
    w_fade = r_fade;
    w_cnt = r_cnt;
    w_restart = 1'b0;
    w_quit = 1'b0;
    w_up_step = 1'b0;
    w_dn_step = 1'b0;
    if (w_fs)
      case (r_state)
        IDLE:
          if (w_pend.select) begin
            w_state = COUNTDOWN;
            w_cnt = '0;
            w_restart = 1'b1;
          end
        PLAY:
          if (w_pend.pause || song_done) begin
            w_item = song_done ? ITEM_RESTART : ITEM_RESUME;
            w_up_step = 1'b1;
          end
        FADE_IN: w_up_step = 1'b1;
        MENU:
          if (w_pend.pause) w_dn_step = 1'b1;
          else if (w_pend.select && r_item == ITEM_QUIT) begin
            w_state = IDLE;
            w_fade = 4'd0;
            w_item = ITEM_RESUME;
            w_quit = 1'b1;
          end else if (w_pend.select) begin
            w_restart = r_item == ITEM_RESTART;
            w_dn_step = 1'b1;
          end else if (w_pend.up != w_pend.down) w_item = menu_move(r_item, w_pend.up, ILAST);
        FADE_OUT: {w_up_step, w_dn_step} = w_pend.pause ? 2'b10 : 2'b01;
        COUNTDOWN:
          if (w_pend.pause) w_up_step = 1'b1;
          else if (r_cnt == C_LAST) w_state = PLAY;
          else w_cnt = r_cnt + 1'b1;
        default: w_state = IDLE;
      endcase
    if (w_up_step) begin
      w_fade = (r_fade == FMAX) ? FMAX : r_fade + 4'd1;
      w_state = (w_fade == FMAX) ? MENU : FADE_IN;
    end
    if (w_dn_step) begin
      w_fade = (r_fade == 4'd0) ? 4'd0 : r_fade - 4'd1;
      w_state = (w_fade == 4'd0) ? COUNTDOWN : FADE_OUT;
      w_cnt = '0;
    end
  end
  always_ff @(posedge clk65 or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_item <= ITEM_RESUME;
      r_fade <= 4'd0;
      r_cnt <= '0;
      r_restart <= 1'b0;
      r_quit <= 1'b0;
    end else begin
      r_state <= w_state;
      r_item <= w_item;
      r_fade <= w_fade;
      r_cnt <= w_cnt;
      r_restart <= w_restart;
      r_quit <= w_quit;
    end
  assign pause = (r_state == FADE_IN) || (r_state == MENU) || (r_state == FADE_OUT);
  assign game_run = r_state == PLAY;
  assign countdown = (r_state != COUNTDOWN) ? 2'd0 : (r_cnt < C_THIRD) ? 2'd3 : (r_cnt < C_TWO) ? 2'd2 : 2'd1;
  assign menu_item = r_item;
  assign fade_level = r_fade;
  assign restart_pulse = r_restart;
  assign quit_pulse = r_quit;
endmodule

// File: doc/av_menu_controller.md
Name: av_menu_controller

Overview:
- Sequences the pause/menu overlay for the 1024x768 (clk65) video path: idle, play, fade-in, menu navigation, fade-out, resume countdown.
- Takes single-cycle button pulses and the raster counters; drives the menu graphics block (pause, highlighted item, fade level) and gates game logic (game_run, restart/quit pulses).
- All visual state changes only at frame boundaries to avoid tearing.

Parameters:
- N_ITEMS, 3, menu entries: 0=Resume, 1=Restart, 2=Quit.
- FADE_MAX, 15, final fade level; one step per frame; fits fade_level[3:0].
- COUNTDOWN_FRAMES, 180, resume countdown length in frames (3 s at 60 Hz); must be a multiple of 3.

Ports:
- clk65  in  1  65 MHz pixel clock
- reset_n  in  1  asynchronous, active-low reset
- hcount  in  11  raster x
- vcount  in  10  raster y
- btn_pause  in  1  debounced one-cycle pulse
- btn_up  in  1  debounced one-cycle pulse
- btn_down  in  1  debounced one-cycle pulse
- btn_select  in  1  debounced one-cycle pulse
- song_done  in  1  level; song finished
- pause  out  1  overlay enable to menu graphics
- menu_item  out  2  highlighted entry
- fade_level  out  4  overlay opacity 0..FADE_MAX
- game_run  out  1  game logic advance enable
- countdown  out  2  digit shown, 3/2/1; 0 when not counting
- restart_pulse  out  1  one-cycle song restart
- quit_pulse  out  1  one-cycle return to title

Behaviour:
- Reset (async, reset_n=0): state IDLE; all outputs 0; pending flags, frame counter and fade cleared.
- frame_start: registered (hcount==0 && vcount==0). Compare true at cycle N gives frame_start high at N+1. FSM acts at the edge ending N+1. Registered outputs are visible at N+2.
- Pending flags (pause, up, down, select):
  - Sticky; a pulse sets its flag.
  - On a frame_start cycle, each flag loads the current-cycle pulse instead of OR-ing with the old value, so a same-cycle event carries to the next frame.
  - The FSM consumes the old flag values.
- Event priority per frame: pause > select > up/down. Up and down together means no move.
- States:
  - IDLE: game_run=0, pause=0. select → COUNTDOWN, restart_pulse=1.
  - PLAY: game_run=1. pause pending → FADE_IN. song_done=1 → FADE_IN with menu_item=1.
  - FADE_IN: pause=1, game_run=0. fade_level+1 per frame. At FADE_MAX → MENU. Button events are ignored.
  - MENU: pause=1, fade=FADE_MAX.
    - up/down move menu_item with wrap: 0↔N_ITEMS-1.
    - select on item 0, or pause pending → FADE_OUT.
    - select on item 1 → restart_pulse=1, then FADE_OUT.
    - select on item 2 → quit_pulse=1, then IDLE; fade and pause are forced to 0 and menu_item to 0.
  - FADE_OUT: fade_level-1 per frame. Reaching 0 → COUNTDOWN, pause=0. A pause pending → FADE_IN, continuing from the current fade level.
  - COUNTDOWN: game_run=0. countdown=3 for frame_cnt < CF/3, 2 for < 2CF/3, else 1. After COUNTDOWN_FRAMES frames → PLAY, countdown=0. A pause pending → FADE_IN, countdown=0.
- menu_item resets to 0 on entry to FADE_IN from PLAY unless song_done, which sets 1.
- Pulses: exactly one clk65 cycle, coincident with the state change.
- frame_cnt width: $clog2(COUNTDOWN_FRAMES+1); cleared on COUNTDOWN entry.
- fade_level saturates at 0 and FADE_MAX, never wraps.
- reset_n asserted mid-fade or mid-countdown: immediate return to the reset values; no pulse emitted.

Decomposition:
- Package av_menu_pkg:
  - state enum (IDLE, PLAY, FADE_IN, MENU, FADE_OUT, COUNTDOWN)
  - item encodings ITEM_RESUME/RESTART/QUIT
  - FADE_MAX default
- Sub-module av_event_latch: frame_start generation plus the four pending flags with the load-on-frame rule. The FSM stays in the top.

Test Plan:
- Reset, then btn_select pulse mid-frame → next frame: restart_pulse 1 cycle, countdown=3. After 60/120/180 frames: countdown 2/1/0, game_run=1.
- PLAY, btn_pause → fade_level counts 1..15 over 15 frames, pause=1 from the first frame. MENU reached on frame 15; game_run=0 throughout.
- MENU item 0: btn_up → menu_item=2 (wrap). btn_down ×2 → 1. btn_up and btn_down in the same frame → unchanged.
- MENU item 1, btn_select → restart_pulse exactly 1 cycle. Fade 15→0 over 15 frames, then countdown 3.
- btn_pause pulse on the frame_start cycle itself → acted on the following frame, not the current one. Two pulses in one frame → single transition.
- reset_n low during FADE_OUT at fade_level=7 → all outputs 0 asynchronously, state IDLE. song_done in PLAY → MENU with menu_item=1.
